// File: rtl/umem_arbiter.sv
// Arbiter sharing one single-ported unified memory between fetch (I, read-only) and MEM (D, read/write),
// favouring D with bounded starvation of I. Optional statistics counters under UMEM_ARB_STATS_EN.
module umem_arbiter #(
    parameter int AW           = 10,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    output logic          stall_if,
    output logic          stall_mem,
`ifdef UMEM_ARB_STATS_EN
    output logic [31:0]   stat_conflicts,
    output logic [31:0]   stat_if_wait,
`endif
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] MEM_LAT_C = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_C  = 4'(STARVE_LIMIT);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;     // 1 = D owns the current access
    logic [2:0]      lat_q, lat_d;
    logic [3:0]      starve_q, starve_d;
    logic            m_en_q, m_en_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [31:0]     m_wdata_q, m_wdata_d;
    logic            if_done_q, if_done_d;
    logic            d_done_q, d_done_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    // Next-state, grant decision and output next values
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (d_req && ((starve_q < STARVE_C) || !if_req)) begin
                    state_d   = S_ISSUE;
                    owner_d   = 1'b1;
                    m_en_d    = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr[AW+1:2];
                    m_wdata_d = d_wdata;
                    if (if_req && (starve_q < STARVE_C)) begin
                        starve_d = starve_q + 4'd1;
                    end else begin
                        starve_d = starve_q;
                    end
                end else if (if_req) begin
                    state_d  = S_ISSUE;
                    owner_d  = 1'b0;
                    m_en_d   = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = if_addr[AW+1:2];
                    starve_d = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // Stores complete without waiting for the memory pipeline
                if (owner_q && m_we_q) begin
                    state_d  = S_DONE;
                    d_done_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    lat_d   = 3'd1;
                end
            end
            S_WAIT: begin
                if (lat_q == MEM_LAT_C) begin
                    state_d = S_DONE;
                    lat_d   = 3'd0;
                    if (owner_q) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = m_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            lat_q      <= 3'd0;
            starve_q   <= 4'd0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= 32'd0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_en      = m_en_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = d_req & ~d_done_q;

`ifdef UMEM_ARB_STATS_EN
    logic [31:0] stat_conflicts_q;
    logic [31:0] stat_if_wait_q;

    // Contention and fetch-stall statistics, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_conflicts_q <= 32'd0;
            stat_if_wait_q   <= 32'd0;
        end else begin
            if ((state_q == S_IDLE) && if_req && d_req) begin
                stat_conflicts_q <= stat_conflicts_q + 32'd1;
            end
            if (stall_if) begin
                stat_if_wait_q <= stat_if_wait_q + 32'd1;
            end
        end
    end

    assign stat_conflicts = stat_conflicts_q;
    assign stat_if_wait   = stat_if_wait_q;
`endif

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed self-checking bench for umem_arbiter with a 2-cycle-latency memory model.
module tb_umem_arbiter;
    localparam int AW = 10;
    localparam int MEM_LAT = 2;
    localparam int STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [31:0]   if_addr, d_addr, d_wdata;
    logic [31:0]   if_rdata, d_rdata;
    logic          if_done, d_done, stall_if, stall_mem;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic [31:0]   rd_pipe;
    logic [31:0]   mem [0:1023];
`ifdef UMEM_ARB_STATS_EN
    logic [31:0]   stat_conflicts, stat_if_wait;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    umem_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
`ifdef UMEM_ARB_STATS_EN
        .stat_conflicts(stat_conflicts), .stat_if_wait(stat_if_wait),
`endif
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Memory model: writes on strobe, reads valid two cycles after strobe
    always @(posedge clk) begin
        if (reset) begin
            mem[0] <= 32'hA5A5_0000;
            mem[5] <= 32'h8C22_0004;
            mem[7] <= 32'h1234_5678;
        end else if (m_en && m_we) begin
            mem[m_addr] <= m_wdata;
        end
        rd_pipe <= (m_en && !m_we) ? mem[m_addr] : 32'hBAD0_BAD0;
        m_rdata <= rd_pipe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // Wait for a done pulse; returns cycles since c0, or -1 on timeout
    task automatic wait_done(input bit on_d, input int c0, input int budget, output int lat);
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if ((on_d && d_done) || (!on_d && if_done)) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    initial begin
        int c0, lat, n_g;
        logic [31:0] grants [0:5];
        logic [31:0] exp_g  [0:5];

        reset = 1'b1;
        idle_inputs();

        // 1: reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            tick();
            chk("rst m_en", {31'd0, m_en}, 32'd0);
            chk("rst m_we", {31'd0, m_we}, 32'd0);
            chk("rst if_done", {31'd0, if_done}, 32'd0);
            chk("rst d_done", {31'd0, d_done}, 32'd0);
            chk("rst m_addr", {22'd0, m_addr}, 32'd0);
        end
        idle_inputs();
        reset = 1'b0;
        tick();

        // 2: single fetch read
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0014;
        #1;
        chk("s2 stall_if c0", {31'd0, stall_if}, 32'd1);
        tick();
        chk("s2 m_en c1", {31'd0, m_en}, 32'd1);
        chk("s2 m_addr c1", {22'd0, m_addr}, 32'd5);
        chk("s2 m_we c1", {31'd0, m_we}, 32'd0);
        tick();
        chk("s2 m_en c2", {31'd0, m_en}, 32'd0);
        wait_done(1'b0, c0, 20, lat);
        chk("s2 if_done cycle", lat, MEM_LAT + 2);
        chk("s2 if_rdata", if_rdata, 32'h8C22_0004);
        chk("s2 stall_if done", {31'd0, stall_if}, 32'd0);
        if_req = 1'b0;
        tick();

        // 3: simultaneous fetch and store, D first
        do_reset(2);
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h0000_0000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("s3 stall_mem c0", {31'd0, stall_mem}, 32'd1);
        tick();
        chk("s3 m_en c1", {31'd0, m_en}, 32'd1);
        chk("s3 m_we c1", {31'd0, m_we}, 32'd1);
        chk("s3 m_addr c1", {22'd0, m_addr}, 32'd16);
        chk("s3 m_wdata c1", m_wdata, 32'hDEAD_BEEF);
        tick();
        chk("s3 d_done c2", {31'd0, d_done}, 32'd1);
        chk("s3 stall_mem c2", {31'd0, stall_mem}, 32'd0);
        chk("s3 if_done c2", {31'd0, if_done}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        wait_done(1'b0, c0, 30, lat);
        chk("s3 if_done cycle", lat, 32'd7);
        chk("s3 if_rdata", if_rdata, 32'hA5A5_0000);
        if_req = 1'b0;
        tick();
`ifdef UMEM_ARB_STATS_EN
        chk("s6 stat_conflicts", stat_conflicts, 32'd1);
        chk("s6 stat_if_wait", stat_if_wait, 32'd7);
`endif
        // Load back the stored word
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        wait_done(1'b1, c0, 20, lat);
        chk("s3 load cycle", lat, MEM_LAT + 2);
        chk("s3 load d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();

        // 4: starvation bound
        do_reset(2);
        if_req = 1'b1; if_addr = 32'h0000_0014;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        exp_g[0] = 32'd16; exp_g[1] = 32'd16; exp_g[2] = 32'd16;
        exp_g[3] = 32'd16; exp_g[4] = 32'd5;  exp_g[5] = 32'd16;
        for (int i = 0; i < 6; i++) grants[i] = 32'hFFFF_FFFF;
        n_g = 0;
        for (int k = 0; k < 100 && n_g < 6; k++) begin
            tick();
            if (m_en) begin
                grants[n_g] = {22'd0, m_addr};
                n_g++;
            end
        end
        for (int i = 0; i < 6; i++) chk($sformatf("s4 grant%0d", i), grants[i], exp_g[i]);
        idle_inputs();
        tick();

        // 5: reset during WAIT discards the read
        do_reset(2);
        if_req = 1'b1; if_addr = 32'h8000_001F;
        tick();
        chk("s5 m_en c1", {31'd0, m_en}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk("s5 if_done rst", {31'd0, if_done}, 32'd0);
        chk("s5 m_en rst", {31'd0, m_en}, 32'd0);
        reset = 1'b0;
        c0 = cyc;
        tick();
        chk("s5 if_done c1", {31'd0, if_done}, 32'd0);
        chk("s5 m_en c1 again", {31'd0, m_en}, 32'd1);
        chk("s5 m_addr", {22'd0, m_addr}, 32'd7);
        wait_done(1'b0, c0, 20, lat);
        chk("s5 if_done cycle", lat, MEM_LAT + 2);
        chk("s5 if_rdata", if_rdata, 32'h1234_5678);
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
